alu_writeback_stage: RTL and testbench

//  Stage directly downstream of the ALU. Accepts one ALU result per handshake
//  (Result + NZCV Flags + instruction control), evaluates the instruction's
//  4-bit condition against the architectural NZCV register, and commits flags.

---
 rtl/alu_writeback_stage.sv | 104 ++++++++++
 tb/tb_alu_writeback_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback_stage.sv
// Writeback stage behind the ALU: evaluates the condition code against the
// architectural NZCV register, commits flags and queues register writes in a small FIFO.
module alu_writeback_stage #(
  parameter int DEPTH      = 2,
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_result,
  input  logic [3:0]            in_flags,
  input  logic [3:0]            in_cond,
  input  logic                  in_set_flags,
  input  logic                  in_wr_req,
  input  logic [REG_ADDR_W-1:0] in_rd,
  output logic [3:0]            flags_o,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [31:0]           wb_data,
  output logic [CNT_W-1:0]      annul_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  // Odd condition codes are the complement of the even code below them; 111x is AL/NV.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, base;
    {n, z, c, v} = nzcv;
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return base ^ cond[0];
  endfunction

  logic [3:0]            r_flags;
  logic [CNT_W-1:0]      r_annul;
  logic [OCC_W-1:0]      r_occ;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic                  r_in_ready;
  logic                  r_wb_valid;
  logic [REG_ADDR_W-1:0] r_mem_addr [DEPTH];
  logic [31:0]           r_mem_data [DEPTH];

  logic             w_accept;
  logic             w_pass;
  logic             w_push;
  logic             w_pop;
  logic [OCC_W-1:0] w_occ_next;

  assign w_accept   = in_valid & r_in_ready;
  assign w_pass     = cond_pass(in_cond, r_flags);
  assign w_push     = w_accept & w_pass & in_wr_req;
  assign w_pop      = r_wb_valid & wb_ready;
  assign w_occ_next = r_occ + OCC_W'(w_push) - OCC_W'(w_pop);

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags    <= 4'b0000;
      r_annul    <= '0;
      r_occ      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_in_ready <= 1'b1;
      r_wb_valid <= 1'b0;
    end else begin
      if (w_accept && w_pass && in_set_flags) r_flags <= in_flags;
      if (w_accept && !w_pass && (r_annul != '1)) r_annul <= r_annul + CNT_W'(1);
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_occ      <= w_occ_next;
      r_in_ready <= (w_occ_next != OCC_W'(DEPTH));
      r_wb_valid <= (w_occ_next != '0);
    end
  end

  // NOTE: FIFO storage has no reset; validity is tracked solely by the occupancy counter.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= in_rd;
      r_mem_data[r_wr_ptr] <= in_result;
    end
  end

  assign in_ready  = r_in_ready;
  assign wb_valid  = r_wb_valid;
  assign wb_addr   = r_mem_addr[r_rd_ptr];
  assign wb_data   = r_mem_data[r_rd_ptr];
  assign flags_o   = r_flags;
  assign annul_cnt = r_annul;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Bench for alu_writeback_stage: directed scenarios plus random traffic, compared
// every cycle against a queue-based model of condition evaluation and the write FIFO.
module tb_alu_writeback_stage;

  localparam int DEPTH      = 2;
  localparam int REG_ADDR_W = 4;
  localparam int CNT_W      = 8;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_result;
  logic [3:0]            in_flags;
  logic [3:0]            in_cond;
  logic                  in_set_flags;
  logic                  in_wr_req;
  logic [REG_ADDR_W-1:0] in_rd;
  logic [3:0]            flags_o;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [31:0]           wb_data;
  logic [CNT_W-1:0]      annul_cnt;

  alu_writeback_stage #(.DEPTH(DEPTH), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_flags(in_flags), .in_cond(in_cond), .in_set_flags(in_set_flags),
    .in_wr_req(in_wr_req), .in_rd(in_rd), .flags_o(flags_o),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
    .wb_data(wb_data), .annul_cnt(annul_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [31:0]           data;
  } wb_entry_t;

  wb_entry_t  m_q[$];
  logic [3:0] m_flags = 4'b0000;
  int         m_annul = 0;
  bit         armed   = 1'b0;
  int         n_cmp   = 0;
  int         n_bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Condition table written out literally from the architectural definition.
  function automatic bit spec_pass(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    bit acc, pop, pass;
    if (reset) begin
      m_q.delete();
      m_flags = 4'b0000;
      m_annul = 0;
    end else begin
      acc  = in_valid && (m_q.size() < DEPTH);
      pop  = (m_q.size() > 0) && wb_ready;
      pass = spec_pass(in_cond, m_flags);
      if (pop) m_q.delete(0);
      if (acc) begin
        if (pass) begin
          if (in_set_flags) m_flags = in_flags;
          if (in_wr_req) m_q.push_back('{rd: in_rd, data: in_result});
        end else if (m_annul < CNT_MAX) begin
          m_annul++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("in_ready",  in_ready,  m_q.size() < DEPTH);
      check("wb_valid",  wb_valid,  m_q.size() > 0);
      check("flags_o",   flags_o,   m_flags);
      check("annul_cnt", annul_cnt, m_annul);
      if (m_q.size() > 0) begin
        check("wb_addr", wb_addr, m_q[0].rd);
        check("wb_data", wb_data, m_q[0].data);
      end
    end
  end

  task automatic issue(input logic [3:0] cond, input logic set, input logic wr,
                       input logic [3:0] rd, input logic [31:0] data, input logic [3:0] fl);
    in_valid = 1'b1; in_cond = cond; in_set_flags = set; in_wr_req = wr;
    in_rd = rd; in_result = data; in_flags = fl;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_result = '0; in_flags = '0; in_cond = '0;
    in_set_flags = 1'b0; in_wr_req = 1'b0; in_rd = '0; wb_ready = 1'b1;
    @(negedge clk);
    armed = 1'b1;
    reset = 1'b0;

    // Unconditional write lands at the FIFO head one cycle later.
    issue(4'hE, 1'b1, 1'b1, 4'd3, 32'h0000_0005, 4'b0000);
    in_valid = 1'b0;
    check("t1_wb_valid", wb_valid, 1'b1);
    check("t1_wb_addr",  wb_addr,  4'd3);
    check("t1_wb_data",  wb_data,  32'h5);
    check("t1_flags",    flags_o,  4'b0000);

    // Compare sets Z, EQ then writes, NE is annulled.
    issue(4'hE, 1'b1, 1'b0, 4'd0, 32'h0, 4'b0100);
    issue(4'h0, 1'b0, 1'b1, 4'd1, 32'h7, 4'b0000);
    check("t2_flags",   flags_o, 4'b0100);
    check("t2_wb_addr", wb_addr, 4'd1);
    check("t2_wb_data", wb_data, 32'h7);
    issue(4'h1, 1'b0, 1'b1, 4'd2, 32'h9, 4'b0000);
    in_valid = 1'b0;
    check("t2_annul",    annul_cnt, 8'd1);
    check("t2_wb_valid", wb_valid,  1'b0);

    // Fill while stalled, third request refused, drain in order.
    wb_ready = 1'b0;
    issue(4'hE, 1'b0, 1'b1, 4'd4, 32'hA, 4'b0000);
    issue(4'hE, 1'b0, 1'b1, 4'd5, 32'hB, 4'b0000);
    in_rd = 4'd6; in_result = 32'hC;
    check("t3_full_ready", in_ready, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    wb_ready = 1'b1;
    @(negedge clk);
    check("t3_ready_after_pop", in_ready, 1'b1);
    check("t3_second_head",     wb_addr,  4'd5);
    idle(2);

    // Simultaneous push and pop every cycle.
    for (int i = 0; i < 8; i++) issue(4'hE, 1'b0, 1'b1, 4'(i + 8), $urandom, 4'b0000);
    in_valid = 1'b0;
    check("t4_occupied", wb_valid, 1'b1);
    idle(2);

    // NV never passes; annulled count saturates.
    issue(4'hF, 1'b1, 1'b0, 4'd0, 32'h0, 4'b1111);
    in_valid = 1'b0;
    check("t5_flags_hold", flags_o,   4'b0100);
    check("t5_annul",      annul_cnt, 8'd2);
    repeat (CNT_MAX + 1) issue(4'hF, 1'b1, 1'b1, 4'd1, 32'h1, 4'b1111);
    in_valid = 1'b0;
    check("t5_saturated", annul_cnt, 8'hFF);
    idle(1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      reset        = ($urandom_range(0, 63) == 0);
      in_valid     = ($urandom_range(0, 3) != 0);
      in_cond      = 4'($urandom);
      in_flags     = 4'($urandom);
      in_set_flags = 1'($urandom);
      in_wr_req    = ($urandom_range(0, 3) != 0);
      in_rd        = 4'($urandom);
      in_result    = $urandom;
      wb_ready     = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    reset = 1'b0;
    idle(2);

    // Reset dominates with a full FIFO and a pending request.
    wb_ready = 1'b0;
    issue(4'hF, 1'b0, 1'b0, 4'd0, 32'h0, 4'b0000);
    issue(4'hE, 1'b1, 1'b1, 4'd7, 32'h11, 4'b1010);
    issue(4'hE, 1'b0, 1'b1, 4'd8, 32'h22, 4'b0000);
    check("t6_pre_full", in_ready, 1'b0);
    in_rd = 4'd9;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    check("t6_wb_valid", wb_valid,  1'b0);
    check("t6_flags",    flags_o,   4'b0000);
    check("t6_annul",    annul_cnt, 8'd0);
    check("t6_in_ready", in_ready,  1'b1);
    idle(2);

    armed = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
